// File: rtl/pattern_detect_pkg.sv
// Shared defaults and helpers for the multi-channel pattern detector.
// The reset defaults reproduce the legacy single-channel "010" detector.
package pattern_detect_pkg;

    localparam logic [2:0] PAT_DEF     = 3'b010;
    localparam int         LEN_DEF     = 3;
    localparam logic       OVERLAP_DEF = 1'b1;

    function automatic int len_w(input int pat_max);
        return $clog2(pat_max + 1);
    endfunction

    // Lengths beyond the history depth behave as the full depth.
    function automatic int clamp_len(input int len, input int pat_max);
        return (len > pat_max) ? pat_max : len;
    endfunction

endpackage

// File: rtl/pattern_detect_ch.sv
// One detector channel: history, fill counter, compare, registered hit pulse.
// Optional saturating hit counter is compiled in with HIT_CNT_EN.
module pattern_detect_ch
    import pattern_detect_pkg::*;
#(
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 16,
    parameter int LW      = len_w(PAT_MAX)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               vld,
    input  logic               din,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [LW-1:0]      len,
    input  logic               overlap,
`ifdef HIT_CNT_EN
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   cnt,
`endif
    output logic               hit
);

    // The oldest history bit only matters once combined with the incoming bit,
    // so PAT_MAX-1 stored bits plus din cover a full-length compare.
    logic [PAT_MAX-2:0] hist_q, hist_d;
    logic [PAT_MAX-1:0] hist_nx;
    logic [LW-1:0]      fill_q, fill_d, fill_nx;
    logic               hit_q, hit_d;
    logic               match;

    always_comb begin
        hist_nx = {hist_q, din};
        fill_nx = (fill_q == LW'(PAT_MAX)) ? fill_q : fill_q + LW'(1);
        match   = (len != '0) && (fill_nx >= len);
        for (int i = 0; i < PAT_MAX; i++) begin
            if ((i < int'(len)) && (hist_nx[i] != pattern[i])) begin
                match = 1'b0;
            end
        end

        hist_d = hist_q;
        fill_d = fill_q;
        hit_d  = 1'b0;
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (vld) begin
            hist_d = hist_nx[PAT_MAX-2:0];
            fill_d = (match && !overlap) ? '0 : fill_nx;
            hit_d  = match;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            hit_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            hit_q  <= hit_d;
        end
    end

    assign hit = hit_q;

`ifdef HIT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts in step with the hit register; a clear beats a coincident hit.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
`endif

endmodule

// File: rtl/pattern_detect_mc.sv
// Multi-channel serial pattern detector top: shared active configuration
// plus CH independent channels. Optional hit counters via HIT_CNT_EN.
module pattern_detect_mc
    import pattern_detect_pkg::*;
#(
    parameter int CH      = 4,
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_load,
    input  logic [PAT_MAX-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_MAX+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic [CH-1:0]                data_vld,
    input  logic [CH-1:0]                data_in,
`ifdef HIT_CNT_EN
    input  logic                         cnt_clr,
    output logic [CH*CNT_W-1:0]          hit_cnt,
`endif
    output logic [CH-1:0]                data_out
);

    localparam int LW = len_w(PAT_MAX);

    logic [PAT_MAX-1:0] pat_q, pat_d;
    logic [LW-1:0]      len_q, len_d;
    logic               ovl_q, ovl_d;

    always_comb begin
        pat_d = pat_q;
        len_d = len_q;
        ovl_d = ovl_q;
        if (cfg_load) begin
            pat_d = cfg_pattern;
            len_d = LW'(clamp_len(int'(cfg_len), PAT_MAX));
            ovl_d = cfg_overlap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= PAT_MAX'(PAT_DEF);
            len_q <= LW'(LEN_DEF);
            ovl_q <= OVERLAP_DEF;
        end else begin
            pat_q <= pat_d;
            len_q <= len_d;
            ovl_q <= ovl_d;
        end
    end

    // cfg_load doubles as the channel clear, so load-cycle bits are dropped.
    for (genvar c = 0; c < CH; c++) begin : g_ch
        pattern_detect_ch #(
            .PAT_MAX (PAT_MAX),
            .CNT_W   (CNT_W),
            .LW      (LW)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .clr     (cfg_load),
            .vld     (data_vld[c]),
            .din     (data_in[c]),
            .pattern (pat_q),
            .len     (len_q),
            .overlap (ovl_q),
`ifdef HIT_CNT_EN
            .cnt_clr (cnt_clr),
            .cnt     (hit_cnt[c*CNT_W +: CNT_W]),
`endif
            .hit     (data_out[c])
        );
    end

endmodule

// File: tb/tb_pattern_detect_mc.sv
// Self-checking bench for pattern_detect_mc: vector tables plus hand sequences
// for reload, reset and counter corner cases (counters only with HIT_CNT_EN).
module tb_pattern_detect_mc;

  localparam int CH      = 4;
  localparam int PAT_MAX = 8;
  localparam int CNT_W   = 2;
  localparam int LW      = $clog2(PAT_MAX + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_load;
  logic [PAT_MAX-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic [CH-1:0]      data_vld;
  logic [CH-1:0]      data_in;
  logic [CH-1:0]      data_out;
`ifdef HIT_CNT_EN
  logic               cnt_clr;
  logic [CH*CNT_W-1:0] hit_cnt;
`endif

  pattern_detect_mc #(
    .CH      (CH),
    .PAT_MAX (PAT_MAX),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .data_vld    (data_vld),
    .data_in     (data_in),
`ifdef HIT_CNT_EN
    .cnt_clr     (cnt_clr),
    .hit_cnt     (hit_cnt),
`endif
    .data_out    (data_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] vld;
    logic [CH-1:0] din;
    logic [CH-1:0] exp;
  } vec_t;

  vec_t          tq[$];
  logic [CH-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;

  // scoreboard
  task automatic check_out(input string name);
    logic [CH-1:0] e;
    e = exp_q.pop_front();
    checks++;
    if (data_out !== e) begin
      errors++;
      $display("FAIL %s: data_out=%b expected %b", name, data_out, e);
    end
  endtask

`ifdef HIT_CNT_EN
  task automatic check_cnt(input logic [CH*CNT_W-1:0] e, input string name);
    checks++;
    if (hit_cnt !== e) begin
      errors++;
      $display("FAIL %s: hit_cnt=%b expected %b", name, hit_cnt, e);
    end
  endtask
`endif

  // drivers
  task automatic tick(input logic [CH-1:0] vld, input logic [CH-1:0] din,
                      input logic [CH-1:0] exp, input string name);
    data_vld = vld;
    data_in  = din;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check_out(name);
    data_vld = '0;
  endtask

  task automatic load(input logic [PAT_MAX-1:0] pat, input logic [LW-1:0] len,
                      input logic ovl);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cfg_load    = 1'b1;
    data_vld    = '1;
    data_in     = CH'($urandom_range(0, (1 << CH) - 1));
    exp_q.push_back('0);
    @(posedge clk);
    #1;
    check_out("load");
    cfg_load = 1'b0;
    data_vld = '0;
  endtask

  task automatic run_tbl(input string name);
    for (int i = 0; i < tq.size(); i++) begin
      tick(tq[i].vld, tq[i].din, tq[i].exp, $sformatf("%s[%0d]", name, i));
    end
    tq.delete();
  endtask

  // bits[n-1] is sent first; hits[k] is the expected pulse after bits[k]
  task automatic send_ch(input int ch, input logic [15:0] bits, input int n,
                         input logic [15:0] hits, input string name);
    logic [CH-1:0] v, d, e;
    for (int k = n - 1; k >= 0; k--) begin
      v = '0; d = '0; e = '0;
      v[ch] = 1'b1;
      d[ch] = bits[k];
      e[ch] = hits[k];
      tick(v, d, e, $sformatf("%s[%0d]", name, n - 1 - k));
    end
  endtask

  task automatic do_rst();
    rst         = 1'b1;
    cfg_load    = 1'b1;
    cfg_pattern = 8'h01;
    cfg_len     = LW'(1);
    cfg_overlap = 1'b1;
    data_vld    = '1;
    data_in     = '1;
    exp_q.push_back('0);
    @(posedge clk);
    #1;
    check_out("rst_mid");
    rst      = 1'b0;
    cfg_load = 1'b0;
    data_vld = '0;
  endtask

  initial begin
    logic [7:0] bits8;
    logic [3:0] gap_rows;
    rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    data_vld = '0; data_in = '0;
`ifdef HIT_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('0);
    check_out("reset");
`ifdef HIT_CNT_EN
    check_cnt('0, "reset_cnt");
`endif
    rst = 1'b0;

    // default 010/len3/overlap; ch2 has a valid gap, ch3 never valid
    tq.push_back('{vld: 4'b0111, din: 4'b0010, exp: 4'b0000});
    tq.push_back('{vld: 4'b0111, din: 4'b1101, exp: 4'b0000});
    tq.push_back('{vld: 4'b0011, din: 4'b0110, exp: 4'b0001});
    tq.push_back('{vld: 4'b0111, din: 4'b1001, exp: 4'b0110});
    tq.push_back('{vld: 4'b0111, din: 4'b0100, exp: 4'b0001});
    run_tbl("default");

    // non-overlap, ch0 and ch3 pulse together
    load(8'b010, LW'(3), 1'b0);
    tq.push_back('{vld: 4'b1001, din: 4'b0000, exp: 4'b0000});
    tq.push_back('{vld: 4'b1001, din: 4'b1001, exp: 4'b0000});
    tq.push_back('{vld: 4'b1001, din: 4'b0000, exp: 4'b1001});
    tq.push_back('{vld: 4'b1001, din: 4'b1001, exp: 4'b0000});
    tq.push_back('{vld: 4'b1001, din: 4'b0000, exp: 4'b0000});
    run_tbl("nonovl");

    // 8-bit pattern on ch1 with a 2-cycle valid gap after bit 4
    load(8'b1011_0011, LW'(8), 1'b1);
    bits8 = 8'b1011_0011;
    for (int k = 7; k >= 0; k--) begin
      if (k == 3) begin
        gap_rows = 4'b0010;
        tq.push_back('{vld: 4'b0000, din: gap_rows, exp: 4'b0000});
        tq.push_back('{vld: 4'b0000, din: 4'b0000, exp: 4'b0000});
      end
      tq.push_back('{vld: 4'b0010, din: {2'b00, bits8[k], 1'b0},
                     exp: (k == 0) ? 4'b0010 : 4'b0000});
    end
    run_tbl("gap8");

    // reload after two matching bits discards them
    load(8'b010, LW'(3), 1'b1);
    send_ch(2, 16'b01, 2, 16'b00, "pre_reload");
    load(8'b010, LW'(3), 1'b1);
    send_ch(2, 16'b010, 3, 16'b001, "post_reload");

    // len 0 never pulses
    load(8'h00, LW'(0), 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick('1, CH'($urandom_range(0, (1 << CH) - 1)), '0, $sformatf("len0[%0d]", i));
    end

    // len 12 clamps to 8
    load(8'b1011_0011, LW'(12), 1'b1);
    send_ch(0, 16'b1011_0011, 8, 16'b0000_0001, "len12");

    // pattern bits above len are ignored
    load(8'b1111_1010, LW'(3), 1'b1);
    send_ch(3, 16'b010, 3, 16'b001, "upper_ign");

    // reset mid-stream beats cfg_load and restores the 010 defaults
    load(8'b11, LW'(2), 1'b0);
    send_ch(0, 16'b1, 1, 16'b0, "pre_rst");
    do_rst();
    send_ch(0, 16'b101010, 6, 16'b000101, "post_rst");

    // len 1 back-to-back pulses
    load(8'h01, LW'(1), 1'b1);
    send_ch(1, 16'b1110, 4, 16'b1110, "len1");

`ifdef HIT_CNT_EN
    cnt_clr = 1'b1;
    tick('0, '0, '0, "cnt_clr_tick");
    cnt_clr = 1'b0;
    check_cnt('0, "cnt_cleared");
    send_ch(0, 16'b11111, 5, 16'b11111, "cnt_hits");
    check_cnt(8'b00_00_00_11, "cnt_sat");
    load(8'h01, LW'(1), 1'b1);
    check_cnt(8'b00_00_00_11, "cnt_keep_on_load");
    cnt_clr = 1'b1;
    tick(4'b0001, 4'b0001, 4'b0001, "cnt_clr_hit");
    cnt_clr = 1'b0;
    check_cnt('0, "cnt_clr_wins");
`endif

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
